// File: rtl/frame_buffer_reader_pkg.sv
// Shared types and sizing helpers for the frame buffer scan-out reader.
// Optional continuous-scan mode is enabled by defining FB_READER_LOOP_EN.
package frame_buffer_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    typedef struct packed {
        logic sof;
        logic eol;
        logic eof;
    } flags_t;

    localparam int FLAG_W       = 3;
    localparam int DEF_H_ACTIVE = 320;
    localparam int DEF_V_ACTIVE = 240;
    localparam int FRAME_PIXELS = DEF_H_ACTIVE * DEF_V_ACTIVE;
    localparam int X_W          = $clog2(DEF_H_ACTIVE);
    localparam int Y_W          = $clog2(DEF_V_ACTIVE);

    // Counter width that stays legal for a 1-pixel/1-line raster.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fb_reader_skid_fifo.sv
// Two-entry FIFO holding captured pixels plus their raster flags.
module fb_reader_skid_fifo #(
    parameter int WIDTH = 19
) (
    input  logic             clk_i,
    input  logic             resetn_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic [1:0]       count_o
);

    logic [WIDTH-1:0] ent0_q, ent0_d, ent1_q, ent1_d;
    logic             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;

    // Storage and register state; reset clears payload so outputs idle at zero.
    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            ent0_q   <= {WIDTH{1'b0}};
            ent1_q   <= {WIDTH{1'b0}};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            ent0_q   <= ent0_d;
            ent1_q   <= ent1_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Pointer/occupancy update; flush wins over a concurrent push or pop.
    always_comb begin
        ent0_d   = ent0_q;
        ent1_d   = ent1_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push_i) begin
                if (wr_ptr_q) begin
                    ent1_d = din_i;
                end else begin
                    ent0_d = din_i;
                end
                wr_ptr_d = ~wr_ptr_q;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_d = ~rd_ptr_q;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    assign dout_o  = rd_ptr_q ? ent1_q : ent0_q;
    assign count_o = count_q;

endmodule

// File: rtl/frame_buffer_reader.sv
// Raster scan-out master: issues frame buffer reads, absorbs the 1-cycle read
// latency and streams pixels with sof/eol/eof. FB_READER_LOOP_EN = continuous scan.
module frame_buffer_reader
    import frame_buffer_reader_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 16,
    parameter int                    H_ACTIVE   = 320,
    parameter int                    V_ACTIVE   = 240,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = {ADDR_WIDTH{1'b0}}
) (
    input  logic                  clk_i,
    input  logic                  resetn_i,
    input  logic                  start_i,
    input  logic                  abort_i,
    output logic [ADDR_WIDTH-1:0] addr_rd_o,
    input  logic [DATA_WIDTH-1:0] fb_data_i,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic                  m_sof_o,
    output logic                  m_eol_o,
    output logic                  m_eof_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int X_CW  = cnt_w(H_ACTIVE);
    localparam int Y_CW  = cnt_w(V_ACTIVE);
    localparam int ENT_W = DATA_WIDTH + FLAG_W;
    localparam logic [X_CW-1:0] X_LAST = X_CW'(H_ACTIVE - 1);
    localparam logic [Y_CW-1:0] Y_LAST = Y_CW'(V_ACTIVE - 1);

    state_e                state_q, state_d;
    logic [X_CW-1:0]       x_q, x_d;
    logic [Y_CW-1:0]       y_q, y_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  inflight_q, inflight_d;
    flags_t                iss_flags_q, iss_flags_d;

    logic [ENT_W-1:0]      fifo_dout_s;
    logic [1:0]            fifo_cnt_s;
    flags_t                head_flags_s;
    logic                  m_valid_s, pop_s, rd_en_s, busy_s, done_s;
    logic                  last_x_s, last_y_s;
    logic [2:0]            occ_s;

    assign last_x_s     = (x_q == X_LAST);
    assign last_y_s     = (y_q == Y_LAST);
    assign head_flags_s = flags_t'(fifo_dout_s[ENT_W-1:DATA_WIDTH]);

    // State register: raster counters, address pointer and the read pipeline stage.
    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            state_q     <= IDLE;
            x_q         <= {X_CW{1'b0}};
            y_q         <= {Y_CW{1'b0}};
            addr_q      <= BASE_ADDR;
            inflight_q  <= 1'b0;
            iss_flags_q <= flags_t'(3'b000);
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            addr_q      <= addr_d;
            inflight_q  <= inflight_d;
            iss_flags_q <= iss_flags_d;
        end
    end

    // Next-state: advance the raster on each issued read; abort forces IDLE.
    always_comb begin
        state_d         = state_q;
        x_d             = x_q;
        y_d             = y_q;
        addr_d          = addr_q;
        iss_flags_d.sof = (x_q == {X_CW{1'b0}}) && (y_q == {Y_CW{1'b0}});
        iss_flags_d.eol = last_x_s;
        iss_flags_d.eof = last_x_s && last_y_s;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = READ;
                end else begin
                    state_d = IDLE;
                end
            end
            READ: begin
                if (rd_en_s) begin
                    addr_d = addr_q + ADDR_WIDTH'(1'b1);
                    if (last_x_s) begin
                        x_d = {X_CW{1'b0}};
                        if (last_y_s) begin
`ifdef FB_READER_LOOP_EN
                            // Wrap straight into the next frame so no bubble appears.
                            y_d    = {Y_CW{1'b0}};
                            addr_d = BASE_ADDR;
`else
                            state_d = DRAIN;
`endif
                        end else begin
                            y_d = y_q + Y_CW'(1'b1);
                        end
                    end else begin
                        x_d = x_q + X_CW'(1'b1);
                    end
                end else begin
                    state_d = READ;
                end
            end
            DRAIN: begin
                if (pop_s && head_flags_s.eof) begin
                    state_d = IDLE;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: state_d = IDLE;
        endcase
        if (abort_i) begin
            state_d    = IDLE;
            inflight_d = 1'b0;
        end else begin
            inflight_d = rd_en_s;
        end
        // Park the pointer at the frame origin whenever the scan is idle.
        if (state_d == IDLE) begin
            x_d    = {X_CW{1'b0}};
            y_d    = {Y_CW{1'b0}};
            addr_d = BASE_ADDR;
        end else begin
            addr_d = addr_d;
        end
    end

    // Outputs: read issue keeps FIFO + in-flight at most two, counting this cycle's pop.
    always_comb begin
        m_valid_s = (fifo_cnt_s != 2'd0);
        pop_s     = m_valid_s && m_ready_i;
        occ_s     = {1'b0, fifo_cnt_s} - {2'b00, pop_s} + {2'b00, inflight_q};
        done_s    = pop_s && head_flags_s.eof && !abort_i;
        rd_en_s   = 1'b0;
        busy_s    = 1'b0;
        case (state_q)
            IDLE: begin
                rd_en_s = 1'b0;
                busy_s  = 1'b0;
            end
            READ: begin
                rd_en_s = (occ_s < 3'd2);
                busy_s  = 1'b1;
            end
            DRAIN: begin
                rd_en_s = 1'b0;
                busy_s  = 1'b1;
            end
            default: begin
                rd_en_s = 1'b0;
                busy_s  = 1'b0;
            end
        endcase
    end

    fb_reader_skid_fifo #(
        .WIDTH(ENT_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .resetn_i(resetn_i),
        .flush_i (abort_i),
        .push_i  (inflight_q),
        .pop_i   (pop_s),
        .din_i   ({iss_flags_q, fb_data_i}),
        .dout_o  (fifo_dout_s),
        .count_o (fifo_cnt_s)
    );

    assign addr_rd_o = addr_q;
    assign m_valid_o = m_valid_s;
    assign m_data_o  = fifo_dout_s[DATA_WIDTH-1:0];
    assign m_sof_o   = m_valid_s & head_flags_s.sof;
    assign m_eol_o   = m_valid_s & head_flags_s.eol;
    assign m_eof_o   = m_valid_s & head_flags_s.eof;
    assign busy_o    = busy_s;
    assign done_o    = done_s;

endmodule

// File: tb/tb_frame_buffer_reader.sv
// Self-checking bench for frame_buffer_reader on a 4x3 raster at base 16.
// Define FB_READER_LOOP_EN to exercise the continuous-scan build.
module tb_frame_buffer_reader;

    localparam int          AW   = 32;
    localparam int          DW   = 16;
    localparam int          H    = 4;
    localparam int          V    = 3;
    localparam int          NPIX = H * V;
    localparam logic [31:0] BASE = 32'd16;

    logic          clk = 1'b0;
    logic          resetn_i, start_i, abort_i, m_ready_i;
    logic [AW-1:0] addr_rd_o;
    logic [DW-1:0] fb_data_i, m_data_o;
    logic          m_valid_o, m_sof_o, m_eol_o, m_eof_o, busy_o, done_o;

    always #5 clk = ~clk;

    frame_buffer_reader #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .H_ACTIVE(H), .V_ACTIVE(V), .BASE_ADDR(BASE)
    ) dut (
        .clk_i(clk), .resetn_i(resetn_i), .start_i(start_i), .abort_i(abort_i),
        .addr_rd_o(addr_rd_o), .fb_data_i(fb_data_i), .m_data_o(m_data_o),
        .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_sof_o(m_sof_o),
        .m_eol_o(m_eol_o), .m_eof_o(m_eof_o), .busy_o(busy_o), .done_o(done_o)
    );

    // Memory model: mem[a] = a[15:0], one cycle of read latency.
    always @(posedge clk) fb_data_i <= addr_rd_o[DW-1:0];

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sof;
        logic          eol;
        logic          eof;
    } beat_t;

    typedef struct {
        logic [3:0] rdy_pat;
        logic       restart;
        int         stall;
        int         exp_span;
        int         exp_done;
    } scen_t;

    beat_t sbq[$];
    beat_t exp_tbl[NPIX];
    scen_t scen[4];
    int    n_chk = 0, n_pass = 0;
    int    acc_cnt = 0, done_cnt = 0, first_cyc = 0, last_cyc = 0, cyc_cnt = 0;
    bit    prev_stall = 1'b0;
    beat_t prev_beat;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Output monitor: scoreboard pop on handshake, stall stability, issue lead.
    always @(negedge clk) begin
        beat_t e;
        if (!resetn_i || abort_i) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                chk("stall_hold", 32'({m_valid_o, m_data_o, m_sof_o, m_eol_o, m_eof_o}),
                    32'({1'b1, prev_beat}));
`ifndef FB_READER_LOOP_EN
            if (busy_o) chk("addr_ahead", 32'((addr_rd_o - BASE - 32'(acc_cnt)) <= 32'd2), 32'd1);
`endif
            if (m_valid_o && m_ready_i) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_beat", 32'(m_data_o), 32'hFFFF_FFFF);
                end else begin
                    e = sbq.pop_front();
                    chk("beat", 32'({m_data_o, m_sof_o, m_eol_o, m_eof_o, done_o}), 32'({e, e.eof}));
                    if (acc_cnt == 0) first_cyc = cyc_cnt;
                    last_cyc = cyc_cnt;
                    acc_cnt++;
                end
                if (done_o) done_cnt++;
            end else if (done_o) begin
                chk("done_no_handshake", 32'(done_o), 32'd0);
            end
            prev_stall = m_valid_o && !m_ready_i;
            prev_beat  = '{m_data_o, m_sof_o, m_eol_o, m_eof_o};
        end
    end

    task automatic run_frame(input logic [3:0] pat, input logic restart, input int stall,
                             input int nbeats, input int exp_span, input int exp_done,
                             input bit chk_idle);
        int n;
        for (int i = 0; i < nbeats; i++) sbq.push_back(exp_tbl[i % NPIX]);
        acc_cnt   = 0;
        done_cnt  = 0;
        m_ready_i = (stall > 0) ? 1'b0 : pat[0];
        start_i   = 1'b1;
        tick();
        start_i = 1'b0;
        chk("lat_valid_c1", 32'(m_valid_o), 32'd0);
        tick();
        chk("lat_valid_c2", 32'(m_valid_o), 32'd0);
        tick();
        chk("lat_valid_c3", 32'(m_valid_o), 32'd1);
        if (stall > 0) begin
            repeat (stall) tick();
            chk("stall_addr", addr_rd_o, BASE + 32'd2);
            chk("stall_head", 32'({m_valid_o, m_data_o, m_sof_o}), 32'({1'b1, 16'd16, 1'b1}));
        end
        n = 0;
        while (sbq.size() != 0 && n < 400) begin
            m_ready_i = pat[n % 4];
            start_i   = restart && (n == 3);
            tick();
            n++;
        end
        start_i   = 1'b0;
        m_ready_i = 1'b0;
        chk("drain_in_time", 32'(n < 400), 32'd1);
        chk("done_count", 32'(done_cnt), 32'(exp_done));
        if (exp_span >= 0) chk("beat_span", 32'(last_cyc - first_cyc), 32'(exp_span));
        if (chk_idle) chk("idle_after", 32'({busy_o, m_valid_o}), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        for (int i = 0; i < NPIX; i++)
            exp_tbl[i] = '{DW'(BASE + 32'(i)), (i == 0), ((i % H) == H - 1), (i == NPIX - 1)};
        scen[0] = '{4'b1111, 1'b0, 0, NPIX - 1, 1};
        scen[1] = '{4'b1001, 1'b0, 0, -1, 1};
        scen[2] = '{4'b1111, 1'b0, 18, NPIX - 1, 1};
        scen[3] = '{4'b0110, 1'b0, 0, -1, 1};

        resetn_i = 1'b0; start_i = 1'b0; abort_i = 1'b0; m_ready_i = 1'b0;
        tick(); tick();
        chk("rst_addr", addr_rd_o, BASE);
        chk("rst_outs", 32'({m_valid_o, m_sof_o, m_eol_o, m_eof_o, busy_o, done_o}), 32'd0);
        chk("rst_data", 32'(m_data_o), 32'd0);
        resetn_i = 1'b1;
        tick();

`ifdef FB_READER_LOOP_EN
        run_frame(4'b1111, 1'b0, 0, 3 * NPIX, 3 * NPIX - 1, 3, 1'b0);
        chk("loop_still_busy", 32'(busy_o), 32'd1);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        chk("loop_abort", 32'({busy_o, m_valid_o}), 32'd0);
        sbq.delete();
`else
        foreach (scen[k]) begin
            run_frame(scen[k].rdy_pat, scen[k].restart, scen[k].stall, NPIX,
                      scen[k].exp_span, scen[k].exp_done, 1'b1);
            tick();
        end

        // Abort after five accepted beats.
        for (int i = 0; i < NPIX; i++) sbq.push_back(exp_tbl[i]);
        acc_cnt = 0; done_cnt = 0;
        m_ready_i = 1'b1; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        n = 0;
        while (acc_cnt < 5 && n < 100) begin tick(); n++; end
        chk("abort_reach5", 32'(acc_cnt), 32'd5);
        m_ready_i = 1'b0; abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        chk("abort_outs", 32'({m_valid_o, busy_o, done_o}), 32'd0);
        sbq.delete();
        m_ready_i = 1'b1;
        repeat (4) tick();
        chk("abort_quiet", 32'({m_valid_o, done_cnt[0]}), 32'd0);
        run_frame(4'b1111, 1'b0, 0, NPIX, NPIX - 1, 1, 1'b1);

        // Reset while draining, then a frame with an ignored mid-scan start.
        for (int i = 0; i < NPIX; i++) sbq.push_back(exp_tbl[i]);
        acc_cnt = 0; done_cnt = 0;
        m_ready_i = 1'b1; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        n = 0;
        while (sbq.size() > 2 && n < 100) begin tick(); n++; end
        chk("drain_busy", 32'({busy_o, m_valid_o}), 32'd3);
        resetn_i = 1'b0; m_ready_i = 1'b0;
        tick();
        chk("mid_rst_addr", addr_rd_o, BASE);
        chk("mid_rst_outs", 32'({m_valid_o, m_sof_o, m_eol_o, m_eof_o, busy_o, done_o, m_data_o}), 32'd0);
        resetn_i = 1'b1;
        sbq.delete();
        tick();
        run_frame(4'b1111, 1'b1, 0, NPIX, NPIX - 1, 1, 1'b1);
        m_ready_i = 1'b1;
        repeat (8) tick();
        chk("no_extra_frame", 32'({busy_o, m_valid_o}), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
